// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes and the sign is applied on the final load.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;
    logic                 negate;
    logic [CW-1:0]        count;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // The most negative value negates to itself, which still reads correctly as an unsigned magnitude.
    always_comb begin
        a_neg    = signed_mode & a[WIDTH-1];
        b_neg    = signed_mode & b[WIDTH-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    // Control and datapath share one register block; product moves only when done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            negate  <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        negate <= a_neg ^ b_neg;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        product <= negate ? (~acc_next + 1'b1) : acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed corner cases plus random operations,
// checked every cycle against a countdown-and-arithmetic reference model.
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int total  = 0;
    int passed = 0;
    logic check_en = 1'b0;

    logic               m_busy;
    logic               m_done;
    logic [2*WIDTH-1:0] m_prod;
    logic [2*WIDTH-1:0] m_pending;
    int                 m_left;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] ref_mult(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic s);
        longint xv;
        longint yv;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        return (2*WIDTH)'(xv * yv);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Reference: an accepted start yields the exact product WIDTH+1 edges later.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_prod <= m_pending;
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy    <= 1'b1;
                m_left    <= WIDTH;
                m_pending <= ref_mult(a, b, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("product", 32'(product), 32'(m_prod));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic smv, input logic has_lit,
                                 input logic [2*WIDTH-1:0] lit, input int poke,
                                 input string name);
        int cnt;
        int busy_cnt;
        logic seen;
        start       = 1'b1;
        a           = av;
        b           = bv;
        signed_mode = smv;
        cnt      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) begin
                start       = 1'b0;
                a           = WIDTH'($urandom);
                b           = WIDTH'($urandom);
                signed_mode = 1'($urandom);
            end
            if (poke != 0 && cnt == poke) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
            if (poke != 0 && cnt == poke + 1) start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_latency"}, 32'(cnt), 32'(WIDTH + 1));
        checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        if (has_lit) begin
            checkOutput({name, "_product"}, 32'(product), 32'(lit));
            checkOutput({name, "_model"}, 32'(m_prod), 32'(lit));
        end
    endtask

    task automatic abortOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic seen;
        seen        = 1'b0;
        start       = 1'b1;
        a           = av;
        b           = bv;
        signed_mode = 1'b0;
        for (int cnt = 1; cnt <= 15; cnt++) begin
            @(posedge clk);
            #1;
            if (cnt == 1) start = 1'b0;
            if (cnt == 4) rst = 1'b1;
            if (cnt == 5) begin
                rst = 1'b0;
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_done", 32'(done), 32'd0);
                checkOutput("abort_product", 32'(product), 32'd0);
            end
            if (done) seen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);

        applyStimulus(8'd15, 8'd15, 1'b0, 1'b1, 16'h00E1, 0, "u15x15");
        @(posedge clk); #1;
        applyStimulus(8'd255, 8'd255, 1'b0, 1'b1, 16'hFE01, 0, "u255x255");
        @(posedge clk); #1;
        applyStimulus(8'd0, 8'd200, 1'b0, 1'b1, 16'h0000, 0, "u0x200");
        @(posedge clk); #1;
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 0, "s80x80");
        @(posedge clk); #1;
        applyStimulus(8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1, 0, "sFDx05");
        @(posedge clk); #1;
        applyStimulus(8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080, 0, "s7Fx80");
        @(posedge clk); #1;
        applyStimulus(8'd12, 8'd13, 1'b0, 1'b1, 16'h009C, 3, "poke");
        applyStimulus(8'd2, 8'd3, 1'b0, 1'b1, 16'h0006, 0, "backtoback");
        @(posedge clk); #1;
        abortOp(8'd9, 8'd9);
        applyStimulus(8'd9, 8'd9, 1'b0, 1'b1, 16'h0051, 0, "after_abort");

        // Random operations, sometimes back-to-back, sometimes with idle gaps.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, '0, 0, "rand");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
